parking_occupancy_ctrl: RTL and testbench

PARKING_OCCUPANCY_CTRL -- requirements
Module: parking_occupancy_ctrl

---
 rtl/parking_pkg.sv | 26 ++
 rtl/parking_id_match.sv | 27 ++
 rtl/parking_occupancy_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_parking_occupancy_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared types and encodings for the parking occupancy controller
package parking_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_COMMIT,
        S_RESP
    } state_t;

    localparam logic [2:0] RC_GRANT_CHOSEN = 3'd0;
    localparam logic [2:0] RC_GRANT_ALT    = 3'd1;
    localparam logic [2:0] RC_REJ_INVALID  = 3'd2;
    localparam logic [2:0] RC_REJ_FULL     = 3'd3;
    localparam logic [2:0] RC_EXIT_OK      = 3'd4;
    localparam logic [2:0] RC_ADMIN_CLEAR  = 3'd5;
    localparam logic [2:0] RC_REJ_MODE     = 3'd6;

    localparam logic [1:0] MODE_ENTER = 2'd0;
    localparam logic [1:0] MODE_EXIT  = 2'd1;
    localparam logic [1:0] MODE_ADMIN = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    localparam logic [19:0] DEF_ID_PREFIX = 20'h20230;

endpackage

// File: rtl/parking_id_match.sv
// rtl/parking_id_match.sv - combinational ID to registered-user index lookup
module parking_id_match
    import parking_pkg::*;
#(
    parameter int          NUM_USERS = 12,
    parameter logic [7:0]  USER_BASE = 8'h10,
    parameter logic [19:0] ID_PREFIX = DEF_ID_PREFIX,
    localparam int         IW        = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1
) (
    input  logic [27:0]   id,
    output logic          hit,
    output logic [IW-1:0] index
);

    // Scan downwards so the lowest matching index wins if suffixes alias.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        for (int i = NUM_USERS - 1; i >= 0; i--) begin
            if (id == {ID_PREFIX, USER_BASE + 8'(i)}) begin
                hit   = 1'b1;
                index = IW'(i);
            end
        end
    end

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// rtl/parking_occupancy_ctrl.sv - per-floor slot counters and per-user occupancy with a 4-state request FSM
module parking_occupancy_ctrl
    import parking_pkg::*;
#(
    parameter int          NUM_USERS  = 12,
    parameter int          NUM_FLOORS = 2,
    parameter int          FLR_CAP    = 4,
    parameter logic [19:0] ID_PREFIX  = DEF_ID_PREFIX,
    parameter logic [7:0]  USER_BASE  = 8'h10,
    parameter logic [7:0]  ADMIN_ID   = 8'h05,
    localparam int         FW         = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1,
    localparam int         CW         = $clog2(FLR_CAP + 1)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               MODE,
    input  logic [27:0]              ID,
    input  logic [FW-1:0]            chosen_flr,
    input  logic                     alt_ok,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [2:0]               resp_code,
    output logic [FW-1:0]            resp_flr,
    output logic [NUM_FLOORS*CW-1:0] remain,
    output logic [NUM_USERS-1:0]     occupied
);

    localparam int            IW  = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1;
    localparam logic [CW-1:0] CAP = CW'(FLR_CAP);

    state_t        state, state_nxt;
    logic [1:0]    mode_q;
    logic [27:0]   id_q;
    logic [FW-1:0] chosen_q;
    logic          alt_ok_q;

    logic          hit;
    logic [IW-1:0] idx;
    logic          hit_q, admin_q;
    logic [IW-1:0] idx_q;

    logic          fl_bad, fl_found, fl_alt;
    logic [FW-1:0] fl_flr;
    logic          bad_q, found_q, alt_hit_q;
    logic [FW-1:0] tgt_q;

    logic [2:0]    dec_code;
    logic [FW-1:0] dec_flr;

    logic [CW-1:0] cnt [NUM_FLOORS];
    logic [FW-1:0] user_flr [NUM_USERS];

    parking_id_match #(
        .NUM_USERS (NUM_USERS),
        .USER_BASE (USER_BASE),
        .ID_PREFIX (ID_PREFIX)
    ) u_id_match (
        .id    (id_q),
        .hit   (hit),
        .index (idx)
    );

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = S_LOOKUP;
            end
            S_LOOKUP: state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = S_RESP;
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Floor choice: the requested floor if free, else the lowest other free floor when allowed.
    always_comb begin
        fl_bad   = 1'b1;
        fl_found = 1'b0;
        fl_alt   = 1'b0;
        fl_flr   = '0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (chosen_q == FW'(f)) begin
                fl_bad = 1'b0;
                if (cnt[f] != '0) begin
                    fl_found = 1'b1;
                    fl_flr   = chosen_q;
                end
            end
        end
        if (!fl_bad && !fl_found && alt_ok_q) begin
            for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
                if (chosen_q != FW'(f) && cnt[f] != '0) begin
                    fl_found = 1'b1;
                    fl_alt   = 1'b1;
                    fl_flr   = FW'(f);
                end
            end
        end
    end

    always_comb begin
        dec_code = RC_REJ_INVALID;
        dec_flr  = '0;
        case (mode_q)
            MODE_ENTER: begin
                if (hit_q && !occupied[idx_q] && !bad_q) begin
                    if (found_q) begin
                        dec_code = alt_hit_q ? RC_GRANT_ALT : RC_GRANT_CHOSEN;
                        dec_flr  = tgt_q;
                    end else begin
                        dec_code = RC_REJ_FULL;
                    end
                end
            end
            MODE_EXIT: begin
                if (hit_q && occupied[idx_q]) begin
                    dec_code = RC_EXIT_OK;
                    dec_flr  = user_flr[idx_q];
                end
            end
            MODE_ADMIN: if (admin_q) dec_code = RC_ADMIN_CLEAR;
            default:    dec_code = RC_REJ_MODE;
        endcase
    end

    always_comb begin
        remain = '0;
        for (int f = 0; f < NUM_FLOORS; f++) remain[f*CW +: CW] = cnt[f];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            mode_q    <= MODE_ENTER;
            id_q      <= '0;
            chosen_q  <= '0;
            alt_ok_q  <= 1'b0;
            hit_q     <= 1'b0;
            admin_q   <= 1'b0;
            idx_q     <= '0;
            bad_q     <= 1'b0;
            found_q   <= 1'b0;
            alt_hit_q <= 1'b0;
            tgt_q     <= '0;
            resp_code <= RC_GRANT_CHOSEN;
            resp_flr  <= '0;
            occupied  <= '0;
            for (int u = 0; u < NUM_USERS; u++) user_flr[u] <= '0;
            for (int f = 0; f < NUM_FLOORS; f++) cnt[f] <= CAP;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && req_valid) begin
                mode_q   <= MODE;
                id_q     <= ID;
                chosen_q <= chosen_flr;
                alt_ok_q <= alt_ok;
            end
            if (state == S_LOOKUP) begin
                hit_q     <= hit;
                idx_q     <= idx;
                admin_q   <= (id_q == {ID_PREFIX, ADMIN_ID});
                bad_q     <= fl_bad;
                found_q   <= fl_found;
                alt_hit_q <= fl_alt;
                tgt_q     <= fl_flr;
            end
            if (state == S_COMMIT) begin
                resp_code <= dec_code;
                resp_flr  <= dec_flr;
                case (dec_code)
                    RC_GRANT_CHOSEN, RC_GRANT_ALT: begin
                        occupied[idx_q] <= 1'b1;
                        user_flr[idx_q] <= dec_flr;
                        for (int f = 0; f < NUM_FLOORS; f++)
                            if (dec_flr == FW'(f) && cnt[f] != '0) cnt[f] <= cnt[f] - CW'(1);
                    end
                    RC_EXIT_OK: begin
                        occupied[idx_q] <= 1'b0;
                        for (int f = 0; f < NUM_FLOORS; f++)
                            if (dec_flr == FW'(f) && cnt[f] != CAP) cnt[f] <= cnt[f] + CW'(1);
                    end
                    RC_ADMIN_CLEAR: begin
                        occupied <= '0;
                        for (int f = 0; f < NUM_FLOORS; f++) cnt[f] <= CAP;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// tb/tb_parking_occupancy_ctrl.sv - randomized self-checking bench against a behavioural parking model
module tb_parking_occupancy_ctrl;

    localparam int NU  = 12;
    localparam int NF  = 2;
    localparam int CAP = 4;
    localparam int CW  = 3;
    localparam int FW  = 1;
    localparam logic [27:0] USER0 = 28'h2023010;
    localparam logic [27:0] ADMIN = 28'h2023005;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    MODE = 2'd0;
    logic [27:0]   ID = '0;
    logic [FW-1:0] chosen_flr = '0;
    logic          alt_ok = 1'b0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [2:0]    resp_code;
    logic [FW-1:0] resp_flr;
    logic [NF*CW-1:0] remain;
    logic [NU-1:0] occupied;

    int n_checks = 0;
    int n_fail   = 0;

    int model_rem [NF];
    bit model_occ [NU];
    int model_flr [NU];

    always #5 CLK = ~CLK;

    parking_occupancy_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .MODE       (MODE),
        .ID         (ID),
        .chosen_flr (chosen_flr),
        .alt_ok     (alt_ok),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_code  (resp_code),
        .resp_flr   (resp_flr),
        .remain     (remain),
        .occupied   (occupied)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int f = 0; f < NF; f++) model_rem[f] = CAP;
        for (int u = 0; u < NU; u++) begin
            model_occ[u] = 1'b0;
            model_flr[u] = 0;
        end
    endtask

    function automatic logic [NF*CW-1:0] model_remain();
        logic [NF*CW-1:0] v;
        for (int f = 0; f < NF; f++) v[f*CW +: CW] = CW'(model_rem[f]);
        return v;
    endfunction

    function automatic logic [NU-1:0] model_occupied();
        logic [NU-1:0] v;
        for (int u = 0; u < NU; u++) v[u] = model_occ[u];
        return v;
    endfunction

    task automatic model_apply(input logic [1:0] m, input logic [27:0] id, input int fl, input bit alt,
                               output int code, output int rflr);
        int u;
        bit known;
        u     = int'(id) - int'(USER0);
        known = (u >= 0) && (u < NU);
        code  = 2;
        rflr  = 0;
        case (m)
            2'd0: begin
                if (known && !model_occ[u] && fl < NF) begin
                    if (model_rem[fl] > 0) begin
                        code = 0; rflr = fl;
                    end else begin
                        code = 3;
                        if (alt) begin
                            for (int f = 0; f < NF; f++)
                                if (code == 3 && f != fl && model_rem[f] > 0) begin
                                    code = 1; rflr = f;
                                end
                        end
                    end
                    if (code <= 1) begin
                        model_rem[rflr]--;
                        model_occ[u] = 1'b1;
                        model_flr[u] = rflr;
                    end
                end
            end
            2'd1: begin
                if (known && model_occ[u]) begin
                    code = 4; rflr = model_flr[u];
                    model_occ[u] = 1'b0;
                    if (model_rem[rflr] < CAP) model_rem[rflr]++;
                end
            end
            2'd2: begin
                if (id == ADMIN) begin
                    code = 5;
                    model_reset();
                end
            end
            default: code = 6;
        endcase
    endtask

    task automatic do_req(input logic [1:0] m, input logic [27:0] id, input int fl, input bit alt, input int hold);
        int code, rflr, k;
        model_apply(m, id, fl, alt, code, rflr);
        @(negedge CLK);
        req_valid = 1'b1; MODE = m; ID = id; chosen_flr = FW'(fl); alt_ok = alt; resp_ready = 1'b0;
        k = 0;
        while (!req_ready && k < 50) begin @(negedge CLK); k++; end
        if (!req_ready) check_eq("req_ready_timeout", 32'(req_ready), 32'd1);
        @(posedge CLK);
        #1;
        req_valid = 1'($urandom); MODE = 2'($urandom); ID = 28'($urandom);
        chosen_flr = FW'($urandom); alt_ok = 1'($urandom);
        k = 1;
        @(negedge CLK);
        while (!resp_valid && k < 20) begin k++; @(negedge CLK); end
        check_eq("latency", 32'(k), 32'd3);
        check_eq("resp_code", 32'(resp_code), 32'(code));
        check_eq("resp_flr", 32'(resp_flr), 32'(rflr));
        for (int h = 0; h < hold; h++) begin
            @(negedge CLK);
            check_eq("hold_valid", 32'(resp_valid), 32'd1);
            check_eq("hold_ready", 32'(req_ready), 32'd0);
            check_eq("hold_code", 32'(resp_code), 32'(code));
            check_eq("hold_flr", 32'(resp_flr), 32'(rflr));
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge CLK);
        #1 resp_ready = 1'b0;
        @(negedge CLK);
        check_eq("post_valid", 32'(resp_valid), 32'd0);
        check_eq("remain", 32'(remain), 32'(model_remain()));
        check_eq("occupied", 32'(occupied), 32'(model_occupied()));
    endtask

    task automatic reset_inflight(input int extra);
        @(negedge CLK);
        req_valid = 1'b1; MODE = 2'd0; ID = USER0 + 28'd11; chosen_flr = '0; alt_ok = 1'b1;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 2 + extra; i++) @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        model_reset();
        @(negedge CLK);
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        check_eq("rst_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_remain", 32'(remain), 32'(model_remain()));
        check_eq("rst_occupied", 32'(occupied), 32'(model_occupied()));
        check_eq("rst_code", 32'(resp_code), 32'd0);
    endtask

    function automatic logic [27:0] rand_id();
        int r;
        r = $urandom_range(0, 15);
        if (r < NU) return USER0 + 28'(r);
        if (r == 12) return ADMIN;
        if (r == 13) return 28'h2023099;
        if (r == 14) return USER0 + 28'd12;
        return 28'($urandom);
    endfunction

    initial begin
        int r;
        logic [1:0] m;
        model_reset();
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check_eq("reset_ready", 32'(req_ready), 32'd1);
        check_eq("reset_valid", 32'(resp_valid), 32'd0);
        check_eq("reset_code", 32'(resp_code), 32'd0);
        check_eq("reset_flr", 32'(resp_flr), 32'd0);
        check_eq("reset_remain", 32'(remain), 32'h24);
        check_eq("reset_occupied", 32'(occupied), 32'd0);

        do_req(2'd0, USER0, 0, 1'b0, 0);
        check_eq("first_remain0", 32'(remain[2:0]), 32'd3);
        check_eq("first_occ0", 32'(occupied[0]), 32'd1);
        do_req(2'd0, USER0 + 28'd2, 0, 1'b0, 0);
        do_req(2'd0, USER0 + 28'd3, 0, 1'b0, 1);
        do_req(2'd0, USER0 + 28'd6, 0, 1'b0, 0);
        do_req(2'd0, USER0 + 28'd4, 0, 1'b1, 0);
        check_eq("alt_remain1", 32'(remain[5:3]), 32'd3);
        do_req(2'd0, USER0 + 28'd5, 0, 1'b0, 2);
        do_req(2'd0, USER0, 1, 1'b1, 0);
        do_req(2'd1, USER0 + 28'd1, 0, 1'b0, 0);
        do_req(2'd0, 28'h2023099, 1, 1'b0, 0);
        do_req(2'd1, USER0 + 28'd4, 0, 1'b0, 5);
        do_req(2'd0, USER0 + 28'd7, 1, 1'b0, 0);
        do_req(2'd2, USER0 + 28'd7, 0, 1'b0, 0);
        do_req(2'd2, ADMIN, 0, 1'b0, 0);
        check_eq("admin_remain", 32'(remain), 32'h24);
        do_req(2'd3, USER0, 0, 1'b1, 0);

        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 19);
            if (r < 10)      m = 2'd0;
            else if (r < 16) m = 2'd1;
            else if (r < 18) m = 2'd2;
            else             m = 2'd3;
            do_req(m, rand_id(), $urandom_range(0, 1), 1'($urandom), $urandom_range(0, 3));
        end

        do_req(2'd0, USER0 + 28'd8, 1, 1'b0, 0);
        reset_inflight(0);
        do_req(2'd0, USER0 + 28'd9, 1, 1'b0, 0);
        reset_inflight(1);
        do_req(2'd0, USER0 + 28'd9, 0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
